// File: rtl/ex_mem_branch_stage_if.sv
// EX -> EX/MEM boundary bus: EX-stage inputs, the EX/MEM register, and the fetch redirect.
// The master drives the EX side; the slave is the branch stage that produces the MEM side.
interface ex_mem_branch_stage_if #(
   parameter int unsigned N = 32
);
   logic         stall_in;
   logic         ex_valid;
   logic [N-1:0] ex_pc;
   logic [N-1:0] ex_imm;
   logic         ex_branch;
   logic         ex_jal;
   logic         ex_jalr;
   logic [2:0]   ex_funct3;
   logic [N-1:0] alu_result;
   logic         zero_flag;
   logic         sign_flag;
   logic         overflow_flag;
   logic         carry_flag;
   logic [N-1:0] ex_rs2_data;
   logic [4:0]   ex_rd;
   logic         ex_reg_write;
   logic         ex_mem_read;
   logic         ex_mem_write;

   logic         mem_valid;
   logic [N-1:0] mem_result;
   logic [N-1:0] mem_rs2_data;
   logic [4:0]   mem_rd;
   logic         mem_reg_write;
   logic         mem_mem_read;
   logic         mem_mem_write;
   logic         redirect_valid;
   logic [N-1:0] redirect_pc;
   logic         squash_active;

   modport master (
      output stall_in, ex_valid, ex_pc, ex_imm, ex_branch, ex_jal, ex_jalr, ex_funct3,
             alu_result, zero_flag, sign_flag, overflow_flag, carry_flag,
             ex_rs2_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
      input  mem_valid, mem_result, mem_rs2_data, mem_rd, mem_reg_write, mem_mem_read,
             mem_mem_write, redirect_valid, redirect_pc, squash_active
   );

   modport slave (
      input  stall_in, ex_valid, ex_pc, ex_imm, ex_branch, ex_jal, ex_jalr, ex_funct3,
             alu_result, zero_flag, sign_flag, overflow_flag, carry_flag,
             ex_rs2_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
      output mem_valid, mem_result, mem_rs2_data, mem_rd, mem_reg_write, mem_mem_read,
             mem_mem_write, redirect_valid, redirect_pc, squash_active
   );
endinterface

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with branch/jump resolution from ALU flags, a one-cycle fetch
// redirect, and squashing of the SHADOW wrong-path instructions that follow a taken transfer.
module ex_mem_branch_stage #(
   parameter int unsigned N      = 32,
   parameter int unsigned SHADOW = 2
) (
   input logic                  i_clk,
   input logic                  i_rst,
   ex_mem_branch_stage_if.slave io_bus
);
   localparam int unsigned CW = $clog2(SHADOW + 1);

   typedef enum logic [0:0] {StRun, StShadow} state_e;

   state_e       r_state;
   logic [CW-1:0] r_count;
   logic         r_mem_valid;
   logic [N-1:0] r_mem_result;
   logic [N-1:0] r_mem_rs2_data;
   logic [4:0]   r_mem_rd;
   logic         r_mem_reg_write;
   logic         r_mem_mem_read;
   logic         r_mem_mem_write;
   logic         r_redirect_valid;
   logic [N-1:0] r_redirect_pc;

   logic         w_cond;
   logic         w_taken;
   logic         w_live;
   logic [N-1:0] w_target;
   logic [N-1:0] w_link;

   always_comb begin
      w_cond = 1'b0;
      case (io_bus.ex_funct3)
         3'b000:  w_cond = io_bus.zero_flag;
         3'b001:  w_cond = ~io_bus.zero_flag;
         3'b100:  w_cond = io_bus.sign_flag ^ io_bus.overflow_flag;
         3'b101:  w_cond = ~(io_bus.sign_flag ^ io_bus.overflow_flag);
         // Flags come from A + ~B + 1, so carry set means A >= B unsigned.
         3'b110:  w_cond = ~io_bus.carry_flag;
         3'b111:  w_cond = io_bus.carry_flag;
         default: w_cond = 1'b0;
      endcase
   end

   assign w_taken  = (io_bus.ex_branch & w_cond) | io_bus.ex_jal | io_bus.ex_jalr;
   assign w_live   = io_bus.ex_valid & (r_state == StRun);
   assign w_link   = io_bus.ex_pc + N'(4);
   assign w_target = io_bus.ex_jalr ? {io_bus.alu_result[N-1:1], 1'b0}
                                    : io_bus.ex_pc + io_bus.ex_imm;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state          <= StRun;
         r_count          <= '0;
         r_mem_valid      <= 1'b0;
         r_mem_result     <= '0;
         r_mem_rs2_data   <= '0;
         r_mem_rd         <= '0;
         r_mem_reg_write  <= 1'b0;
         r_mem_mem_read   <= 1'b0;
         r_mem_mem_write  <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         // The redirect is a pulse even when MEM is stalled.
         r_redirect_valid <= 1'b0;
         if (!io_bus.stall_in) begin
            r_mem_valid     <= w_live;
            r_mem_reg_write <= w_live & io_bus.ex_reg_write & ~io_bus.ex_branch;
            r_mem_mem_read  <= w_live & io_bus.ex_mem_read;
            r_mem_mem_write <= w_live & io_bus.ex_mem_write;
            r_mem_result    <= (io_bus.ex_jal | io_bus.ex_jalr) ? w_link : io_bus.alu_result;
            r_mem_rs2_data  <= io_bus.ex_rs2_data;
            r_mem_rd        <= io_bus.ex_rd;
            case (r_state)
               StRun: begin
                  if (w_live && w_taken) begin
                     r_redirect_valid <= 1'b1;
                     r_redirect_pc    <= w_target;
                     r_count          <= CW'(SHADOW);
                     r_state          <= StShadow;
                  end
               end
               StShadow: begin
                  if (io_bus.ex_valid) begin
                     r_count <= r_count - CW'(1);
                     if (r_count == CW'(1)) r_state <= StRun;
                  end
               end
               default: r_state <= StRun;
            endcase
         end
      end
   end

   assign io_bus.mem_valid      = r_mem_valid;
   assign io_bus.mem_result     = r_mem_result;
   assign io_bus.mem_rs2_data   = r_mem_rs2_data;
   assign io_bus.mem_rd         = r_mem_rd;
   assign io_bus.mem_reg_write  = r_mem_reg_write;
   assign io_bus.mem_mem_read   = r_mem_mem_read;
   assign io_bus.mem_mem_write  = r_mem_mem_write;
   assign io_bus.redirect_valid = r_redirect_valid;
   assign io_bus.redirect_pc    = r_redirect_pc;
   assign io_bus.squash_active  = (r_state == StShadow);
endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Directed bench for ex_mem_branch_stage: an operand-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_ex_mem_branch_stage;
   localparam int SHADOW = 2;

   logic clk;
   logic rst;
   int   n_vec  = 0;
   int   n_fail = 0;
   bit   started = 0;

   // Source operands of the current EX instruction; the model reasons on these directly.
   logic [31:0] op_a, op_b;

   ex_mem_branch_stage_if #(.N(32)) bus ();

   ex_mem_branch_stage #(.N(32), .SHADOW(SHADOW)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: expected outputs after each rising edge.
   logic        e_valid, e_rw, e_mr, e_mw, e_rv;
   logic [31:0] e_result, e_rs2, e_rpc;
   logic [4:0]  e_rd;
   int          e_cnt;

   initial begin
      e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_rv = 0;
      e_result = 0; e_rs2 = 0; e_rpc = 0; e_rd = 0; e_cnt = 0;
   end

   always @(posedge clk) begin
      logic        take, live;
      logic [31:0] tgt;
      started = 1;
      if (rst) begin
         e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_rv = 0; e_rpc = 0; e_cnt = 0;
      end else begin
         e_rv = 0;
         if (!bus.stall_in) begin
            live = bus.ex_valid && (e_cnt == 0);
            take = 0;
            if (bus.ex_branch) begin
               case (bus.ex_funct3)
                  3'b000: take = (op_a == op_b);
                  3'b001: take = (op_a != op_b);
                  3'b100: take = ($signed(op_a) <  $signed(op_b));
                  3'b101: take = ($signed(op_a) >= $signed(op_b));
                  3'b110: take = (op_a <  op_b);
                  3'b111: take = (op_a >= op_b);
                  default: take = 0;
               endcase
            end
            if (bus.ex_jal || bus.ex_jalr) take = 1;
            tgt = bus.ex_jalr ? (bus.alu_result / 2) * 2 : bus.ex_pc + bus.ex_imm;
            e_valid = live;
            e_rw = live && bus.ex_reg_write && !bus.ex_branch;
            e_mr = live && bus.ex_mem_read;
            e_mw = live && bus.ex_mem_write;
            if (live) begin
               e_result = (bus.ex_jal || bus.ex_jalr) ? bus.ex_pc + 4 : bus.alu_result;
               e_rs2    = bus.ex_rs2_data;
               e_rd     = bus.ex_rd;
            end
            if (live && take) begin
               e_rv  = 1;
               e_rpc = tgt;
               e_cnt = SHADOW;
            end else if (e_cnt > 0 && bus.ex_valid) begin
               e_cnt = e_cnt - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("mem_valid", 32'(bus.mem_valid), 32'(e_valid));
         chk("mem_reg_write", 32'(bus.mem_reg_write), 32'(e_rw));
         chk("mem_mem_read", 32'(bus.mem_mem_read), 32'(e_mr));
         chk("mem_mem_write", 32'(bus.mem_mem_write), 32'(e_mw));
         chk("redirect_valid", 32'(bus.redirect_valid), 32'(e_rv));
         chk("redirect_pc", bus.redirect_pc, e_rpc);
         chk("squash_active", 32'(bus.squash_active), 32'(e_cnt != 0));
         if (e_valid) begin
            chk("mem_result", bus.mem_result, e_result);
            chk("mem_rs2_data", bus.mem_rs2_data, e_rs2);
            chk("mem_rd", 32'(bus.mem_rd), 32'(e_rd));
         end
      end
   end

   // cls: 0 ALU, 1 branch, 2 JAL, 3 JALR, 4 load, 5 store. Returns at the next falling edge.
   task automatic op(input logic v, input int cls, input logic [2:0] f3, input logic [31:0] pc,
                     input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd);
      logic [32:0] d;
      d = {1'b0, a} + {1'b0, ~b} + 33'd1;
      op_a = a;
      op_b = b;
      bus.ex_valid      = v;
      bus.ex_pc         = pc;
      bus.ex_imm        = imm;
      bus.ex_branch     = (cls == 1);
      bus.ex_jal        = (cls == 2);
      bus.ex_jalr       = (cls == 3);
      bus.ex_funct3     = f3;
      bus.alu_result    = (cls == 1) ? d[31:0] : a + b;
      bus.zero_flag     = (d[31:0] == 0);
      bus.sign_flag     = d[31];
      bus.overflow_flag = (a[31] != b[31]) && (d[31] != a[31]);
      bus.carry_flag    = d[32];
      bus.ex_rs2_data   = b;
      bus.ex_rd         = rd;
      bus.ex_reg_write  = (cls != 1) && (cls != 5);
      bus.ex_mem_read   = (cls == 4);
      bus.ex_mem_write  = (cls == 5);
      @(negedge clk);
   endtask

   task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      op(1'b1, 0, 3'b000, 32'h0, 32'h0, a, b, rd);
   endtask

   initial begin
      bus.stall_in = 1'b0;
      rst = 1'b1;
      op(1'b1, 2, 3'b000, 32'h10, 32'h8, 32'h1, 32'h2, 5'd1);
      op(1'b1, 2, 3'b000, 32'h10, 32'h8, 32'h1, 32'h2, 5'd1);
      chk("rst mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst redirect_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rst redirect_pc", bus.redirect_pc, 32'd0);
      chk("rst squash", 32'(bus.squash_active), 32'd0);
      rst = 1'b0;

      // BEQ taken, two squashed slots, third captured.
      op(1'b1, 1, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 5'd0);
      chk("beq redirect_valid", 32'(bus.redirect_valid), 32'd1);
      chk("beq redirect_pc", bus.redirect_pc, 32'h120);
      chk("beq reg_write", 32'(bus.mem_reg_write), 32'd0);
      alu(32'd1, 32'd2, 5'd3);
      chk("beq shadow1 valid", 32'(bus.mem_valid), 32'd0);
      chk("beq shadow1 redirect", 32'(bus.redirect_valid), 32'd0);
      alu(32'd1, 32'd2, 5'd3);
      chk("beq shadow2 valid", 32'(bus.mem_valid), 32'd0);
      chk("beq shadow2 squash", 32'(bus.squash_active), 32'd0);
      alu(32'd7, 32'd8, 5'd4);
      chk("beq third valid", 32'(bus.mem_valid), 32'd1);
      chk("beq third result", bus.mem_result, 32'd15);

      // Unsigned/signed compares with A=1, B=0xFFFFFFFF.
      op(1'b1, 1, 3'b110, 32'h200, 32'h10, 32'h1, 32'hFFFF_FFFF, 5'd0);
      chk("bltu taken", 32'(bus.redirect_valid), 32'd1);
      chk("bltu target", bus.redirect_pc, 32'h210);
      alu(32'd3, 32'd4, 5'd6);
      alu(32'd3, 32'd4, 5'd6);
      op(1'b1, 1, 3'b111, 32'h220, 32'h10, 32'h1, 32'hFFFF_FFFF, 5'd0);
      chk("bgeu not taken", 32'(bus.redirect_valid), 32'd0);
      op(1'b1, 1, 3'b100, 32'h224, 32'h10, 32'h1, 32'hFFFF_FFFF, 5'd0);
      chk("blt not taken", 32'(bus.redirect_valid), 32'd0);
      op(1'b1, 1, 3'b101, 32'h228, 32'h10, 32'h1, 32'hFFFF_FFFF, 5'd0);
      chk("bge taken", 32'(bus.redirect_valid), 32'd1);
      chk("bge target", bus.redirect_pc, 32'h238);
      alu(32'd3, 32'd4, 5'd6);
      alu(32'd3, 32'd4, 5'd6);

      // JALR: target clears bit 0, link is pc+4.
      op(1'b1, 3, 3'b000, 32'h40, 32'h0, 32'h2000, 32'h3, 5'd5);
      chk("jalr redirect_pc", bus.redirect_pc, 32'h2002);
      chk("jalr mem_result", bus.mem_result, 32'h44);
      chk("jalr reg_write", 32'(bus.mem_reg_write), 32'd1);
      alu(32'd3, 32'd4, 5'd6);
      alu(32'd3, 32'd4, 5'd6);

      // Stall right after a taken branch: single redirect pulse, shadow frozen.
      op(1'b1, 1, 3'b000, 32'h300, 32'h40, 32'd9, 32'd9, 5'd0);
      chk("stall br redirect", 32'(bus.redirect_valid), 32'd1);
      bus.stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu(32'd10, 32'd11, 5'd7);
         chk("stall redirect low", 32'(bus.redirect_valid), 32'd0);
         chk("stall squash held", 32'(bus.squash_active), 32'd1);
         chk("stall mem held", 32'(bus.mem_valid), 32'd1);
      end
      bus.stall_in = 1'b0;
      alu(32'd10, 32'd11, 5'd7);
      chk("unstall shadow1", 32'(bus.mem_valid), 32'd0);
      chk("unstall squash1", 32'(bus.squash_active), 32'd1);
      alu(32'd10, 32'd11, 5'd7);
      chk("unstall shadow2", 32'(bus.mem_valid), 32'd0);
      alu(32'd10, 32'd11, 5'd7);
      chk("unstall capture", 32'(bus.mem_valid), 32'd1);

      // Taken JAL in the shadow of a taken BNE must not redirect.
      op(1'b1, 1, 3'b001, 32'h400, 32'h100, 32'd1, 32'd2, 5'd0);
      chk("bne redirect_pc", bus.redirect_pc, 32'h500);
      op(1'b1, 2, 3'b000, 32'h404, 32'h1000, 32'd0, 32'd0, 5'd1);
      chk("shadow jal no redirect", 32'(bus.redirect_valid), 32'd0);
      chk("shadow jal bubbled", 32'(bus.mem_valid), 32'd0);
      alu(32'd1, 32'd1, 5'd2);
      op(1'b1, 4, 3'b010, 32'h40c, 32'h0, 32'h80, 32'h4, 5'd8);
      chk("load captured", 32'(bus.mem_mem_read), 32'd1);

      // Misaligned JAL target; invalid slots do not consume the shadow; taken at last slot.
      op(1'b1, 2, 3'b000, 32'h600, 32'h22, 32'd0, 32'd0, 5'd1);
      chk("misaligned target", bus.redirect_pc, 32'h622);
      op(1'b0, 0, 3'b000, 32'h0, 32'h0, 32'd0, 32'd0, 5'd0);
      alu(32'd1, 32'd1, 5'd2);
      chk("invalid no decrement", 32'(bus.squash_active), 32'd1);
      op(1'b1, 1, 3'b000, 32'h700, 32'h8, 32'd4, 32'd4, 5'd0);
      chk("last slot no redirect", 32'(bus.redirect_valid), 32'd0);
      chk("last slot run", 32'(bus.squash_active), 32'd0);
      op(1'b1, 5, 3'b010, 32'h704, 32'h0, 32'h100, 32'h55, 5'd0);
      chk("store captured", 32'(bus.mem_mem_write), 32'd1);

      // Reset mid-shadow, coincident with a taken branch.
      op(1'b1, 2, 3'b000, 32'h800, 32'h4, 32'd0, 32'd0, 5'd1);
      rst = 1'b1;
      op(1'b1, 1, 3'b000, 32'h804, 32'h40, 32'd3, 32'd3, 5'd0);
      chk("rst shadow redirect", 32'(bus.redirect_valid), 32'd0);
      chk("rst shadow squash", 32'(bus.squash_active), 32'd0);
      chk("rst shadow bubble", 32'(bus.mem_valid), 32'd0);
      rst = 1'b0;
      alu(32'd20, 32'd22, 5'd9);
      chk("post rst capture", bus.mem_result, 32'd42);

      op(1'b0, 0, 3'b000, 32'h0, 32'h0, 32'd0, 32'd0, 5'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
